// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: sizes and FSM states.
package imem_loader_pkg;

    localparam int unsigned MAX_WORDS = 4096;
    localparam int unsigned IMEM_AW   = 12;
    localparam int unsigned LEN_BYTES = 2;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERR
    } state_t;

    // A word count is loadable when it is non-zero and fits the memory.
    function automatic logic len_valid(input logic [8*LEN_BYTES-1:0] n);
        return (n != '0) && (32'(n) <= MAX_WORDS);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Shifts bytes MSB-first into a 32-bit word and flags the 4th byte of each word.
module byte_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0] byte_cnt;

    // Shift register and byte-in-word counter; both hold while shift_en is low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (shift_en) begin
            word     <= {word[23:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    // The byte being shifted in now completes the word.
    always_comb begin
        word_done = shift_en && (byte_cnt == 2'd3);
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed image into instruction memory
// and holds the processor in reset until the image is verified.
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               rx_ready,
    output logic [IMEM_AW-1:0] imem_address,
    output logic [31:0]        imem_data,
    output logic               imem_wren,
    output logic               cpu_reset,
    output logic               done,
    output logic               error
);

    state_t                 state;
    state_t                 state_next;
    logic [7:0]             len_hi;
    logic [IMEM_AW:0]       n_words;
    logic [IMEM_AW-1:0]     word_idx;
    logic [7:0]             csum;
    logic [8*LEN_BYTES-1:0] len_rx;
    logic                   accept;
    logic                   data_shift;
    logic                   word_done;
    logic                   last_word;
    logic [31:0]            packed_word;

    assign accept     = rx_valid && rx_ready;
    assign data_shift = accept && (state == DATA);
    assign len_rx     = {len_hi, rx_data};
    // Index stops at the final word instead of stepping past it, so a
    // 4096-word image never wraps the 12-bit address.
    assign last_word  = (({1'b0, word_idx} + (IMEM_AW+1)'(1)) == n_words);

    assign imem_address = word_idx;
    assign imem_data    = packed_word;

    byte_packer u_packer (
        .clock     (clock),
        .reset     (reset),
        .shift_en  (data_shift),
        .byte_in   (rx_data),
        .word      (packed_word),
        .word_done (word_done)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= LEN_HI;
        end else begin
            state <= state_next;
        end
    end

    // Length capture, running checksum and word index.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len_hi   <= '0;
            n_words  <= '0;
            word_idx <= '0;
            csum     <= '0;
        end else begin
            if ((state == LEN_HI) && accept) begin
                len_hi <= rx_data;
            end
            if ((state == LEN_LO) && accept) begin
                n_words <= len_rx[IMEM_AW:0];
            end
            if (data_shift) begin
                csum <= csum ^ rx_data;
            end
            if ((state == WRITE) && !last_word) begin
                word_idx <= word_idx + IMEM_AW'(1);
            end
        end
    end

    // Next-state logic and Moore outputs.
    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        imem_wren  = 1'b0;
        cpu_reset  = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        unique case (state)
            LEN_HI: begin
                rx_ready = 1'b1;
                if (accept) state_next = LEN_LO;
            end
            LEN_LO: begin
                rx_ready = 1'b1;
                if (accept) state_next = len_valid(len_rx) ? DATA : ERR;
            end
            DATA: begin
                rx_ready = 1'b1;
                if (word_done) state_next = WRITE;
            end
            WRITE: begin
                imem_wren  = 1'b1;
                state_next = last_word ? CHECK : DATA;
            end
            CHECK: begin
                rx_ready = 1'b1;
                if (accept) state_next = (rx_data == csum) ? DONE : ERR;
            end
            DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
            end
            ERR: begin
                error = 1'b1;
            end
            default: begin
                state_next = ERR;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: byte streams with random gaps are
// compared against a stream-level model of the load protocol.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [11:0] imem_address;
    logic [31:0] imem_data;
    logic        imem_wren;
    logic        cpu_reset;
    logic        done;
    logic        error;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        obs_q[$];
    wr_t        exp_q[$];
    logic [7:0] stim[$];
    int         n_checks = 0;
    int         n_errors = 0;
    bit         exp_done;
    bit         exp_len_ok;
    int         exp_n;

    imem_loader dut (
        .clock        (clock),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .imem_address (imem_address),
        .imem_data    (imem_data),
        .imem_wren    (imem_wren),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .error        (error)
    );

    always #5 clock = ~clock;

    // Record every write strobe seen by memory.
    always @(negedge clock) begin
        if (reset === 1'b0 && imem_wren === 1'b1) begin
            obs_q.push_back({imem_address, imem_data});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected writes and outcome computed from the stream format alone.
    task automatic model_stream();
        logic [7:0] x;
        wr_t        w;
        exp_q.delete();
        exp_n      = int'(stim[0]) * 256 + int'(stim[1]);
        exp_len_ok = (exp_n >= 1) && (exp_n <= 4096);
        exp_done   = 1'b0;
        if (!exp_len_ok) return;
        x = 8'h00;
        for (int i = 0; i < exp_n; i++) begin
            w.addr = 12'(i);
            w.data = {stim[2+4*i], stim[3+4*i], stim[4+4*i], stim[5+4*i]};
            for (int j = 0; j < 4; j++) x = x ^ stim[2+4*i+j];
            exp_q.push_back(w);
        end
        exp_done = (stim[2+4*exp_n] == x);
    endtask

    // Offer one byte after an optional idle gap; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        int waited;
        int g;
        g = 0;
        while (g < 6 && int'($urandom_range(99)) < gap) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clock);
            g++;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        waited   = 0;
        while (rx_ready !== 1'b1 && waited < 8) begin
            @(negedge clock);
            waited++;
        end
        ok = (rx_ready === 1'b1);
        if (ok) begin
            @(negedge clock);
            rx_valid = 1'b0;
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        #2;
        reset    = 1'b1;
        rx_valid = 1'b0;
        #1;
        check_eq({tag, "_wren"},     imem_wren,    0);
        check_eq({tag, "_addr"},     imem_address, 0);
        check_eq({tag, "_data"},     imem_data,    0);
        check_eq({tag, "_cpu_rst"},  cpu_reset,    1);
        check_eq({tag, "_done"},     done,         0);
        check_eq({tag, "_error"},    error,        0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_eq({tag, "_ready"}, rx_ready, 1);
    endtask

    task automatic build_stream(input int n, input bit corrupt);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        stim.delete();
        stim.push_back(8'(n >> 8));
        stim.push_back(8'(n));
        if (n < 1 || n > 4096) return;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            stim.push_back(b);
            x = x ^ b;
        end
        stim.push_back(corrupt ? (x ^ 8'($urandom_range(1, 255))) : x);
    endtask

    task automatic run_stream(input string tag, input int gap);
        bit ok;
        bit fourth;
        int idx;
        model_stream();
        obs_q.delete();
        for (int k = 0; k < stim.size(); k++) begin
            send_byte(stim[k], gap, ok);
            if (!ok) begin
                check_eq({tag, "_ready_timeout"}, rx_ready, 1);
                break;
            end
            fourth = exp_len_ok && (k >= 2) && (k < 2 + 4 * exp_n) && (((k - 2) % 4) == 3);
            check_eq({tag, "_wren"}, imem_wren, fourth);
            if (fourth) begin
                idx = (k - 2) / 4;
                check_eq({tag, "_waddr"}, imem_address, exp_q[idx].addr);
                check_eq({tag, "_wdata"}, imem_data,    exp_q[idx].data);
            end
            if (k == stim.size() - 1) begin
                check_eq({tag, "_done"},    done,      exp_done);
                check_eq({tag, "_error"},   error,     !exp_done);
                check_eq({tag, "_cpu_rst"}, cpu_reset, !exp_done);
                check_eq({tag, "_ready_end"}, rx_ready, 0);
            end
        end
        // Bytes offered after the load ends must be refused.
        rx_valid = 1'b1;
        repeat (3) begin
            rx_data = 8'($urandom);
            @(negedge clock);
            check_eq({tag, "_post_ready"}, rx_ready,  0);
            check_eq({tag, "_post_wren"},  imem_wren, 0);
            check_eq({tag, "_post_done"},  done,      exp_done);
            check_eq({tag, "_post_error"}, error,     !exp_done);
        end
        rx_valid = 1'b0;
        check_eq({tag, "_nwrites"}, obs_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) begin
                check_eq({tag, "_log_addr"}, obs_q[i].addr, exp_q[i].addr);
                check_eq({tag, "_log_data"}, obs_q[i].data, exp_q[i].data);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        int sel;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        do_reset("rst0");
        stim = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        run_stream("one_word", 0);

        do_reset("rst1");
        stim = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
        run_stream("two_words", 0);

        do_reset("rst2");
        stim = '{8'h00, 8'h00};
        run_stream("len_zero", 0);

        do_reset("rst3");
        stim = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFF};
        run_stream("bad_csum", 0);

        do_reset("rst4");
        stim = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h2C};
        run_stream("csum_2c", 0);

        do_reset("rst5");
        stim = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        run_stream("gappy", 40);

        // Abandon a load part-way through the first word, then reload.
        do_reset("rst6");
        obs_q.delete();
        for (int k = 0; k < 4; k++) begin
            send_byte(stim[k], 30, ok);
            if (!ok) check_eq("partial_ready_timeout", rx_ready, 1);
        end
        do_reset("mid_rst");
        check_eq("partial_nwrites", obs_q.size(), 0);
        run_stream("after_rst", 40);

        for (int t = 0; t < 12; t++) begin
            do_reset("rst_rand");
            sel = int'($urandom_range(0, 3));
            if (sel == 0) begin
                case ($urandom_range(0, 2))
                    0:       n = 0;
                    1:       n = 4097;
                    default: n = int'($urandom_range(4098, 65535));
                endcase
                build_stream(n, 1'b0);
            end else begin
                build_stream(int'($urandom_range(1, 9)), 1'($urandom_range(0, 1)));
            end
            run_stream("rand", int'($urandom_range(0, 50)));
        end

        do_reset("rst_full");
        build_stream(4096, 1'b0);
        run_stream("full", 0);
        if (obs_q.size() > 0) begin
            check_eq("full_last_addr", obs_q[obs_q.size()-1].addr, 12'hFFF);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
